// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard controller and forwarding_unit.
package hazard_control_unit_pkg;

   localparam int unsigned REG_ADDR_W = 3;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MUL_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_compare.sv
// Combinational load-use detection: the load in EX writes a register read by ID.
module hazard_compare #(
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic                  id_ex_mem_read,
   output logic                  load_use
);

   always_comb begin
      load_use = id_ex_mem_read & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing: load-use stalls, multiply stalls, branch flushes and a
// saturating stall-cycle counter. Outputs are Mealy so hazards act in the detection cycle.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W      = hazard_control_unit_pkg::REG_ADDR_W,
   parameter int unsigned MUL_LATENCY     = 4,
   parameter int unsigned LOAD_USE_STALLS = 1,
   parameter int unsigned FLUSH_CYCLES    = 2,
   parameter int unsigned STALL_CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REG_ADDR_W-1:0]  if_id_rs,
   input  logic [REG_ADDR_W-1:0]  if_id_rt,
   input  logic [REG_ADDR_W-1:0]  id_ex_rt,
   input  logic                   id_ex_mem_read,
   input  logic                   id_ex_mul_start,
   input  logic                   ex_branch_taken,
   output logic                   pc_write,
   output logic                   if_id_write,
   output logic                   id_ex_write,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_mem_bubble,
   output logic                   mul_busy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int unsigned CNT_W = ($clog2(MUL_LATENCY) < 2) ? 2 : $clog2(MUL_LATENCY);

   hcu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             lu;

   hazard_compare #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_compare (
      .if_id_rs       (if_id_rs),
      .if_id_rt       (if_id_rt),
      .id_ex_rt       (id_ex_rt),
      .id_ex_mem_read (id_ex_mem_read),
      .load_use       (lu)
   );

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      mul_busy      = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (id_ex_mul_start) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
                  mul_busy      = 1'b1;
               end else if (lu) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            LOAD_STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end
            MUL_WAIT: begin
               mul_busy = 1'b1;
               // cnt==0 is the release cycle: multiplier still busy, pipeline moves.
               if (cnt != '0) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
               end
            end
            FLUSH: begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         cnt          <= '0;
         stall_cycles <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  if (FLUSH_CYCLES > 1) begin
                     state <= FLUSH;
                     cnt   <= CNT_W'(FLUSH_CYCLES - 2);
                  end
               end else if (id_ex_mul_start) begin
                  state <= MUL_WAIT;
                  cnt   <= CNT_W'(MUL_LATENCY - 2);
               end else if (lu && (LOAD_USE_STALLS > 1)) begin
                  state <= LOAD_STALL;
                  cnt   <= CNT_W'(LOAD_USE_STALLS - 2);
               end
            end
            default: begin
               if (cnt == '0) begin
                  state <= RUN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed and random stimulus for hazard_control_unit, checked against a
// remaining-cycles reference model; a second 4-bit-counter instance covers saturation.
module tb_hazard_control_unit;

   localparam int MUL_LAT = 4;
   localparam int LU_ST   = 1;
   localparam int FL_CYC  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] if_id_rs, if_id_rt, id_ex_rt;
   logic       id_ex_mem_read, id_ex_mul_start, ex_branch_taken;

   logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, mul_busy;
   logic [15:0] stall_cycles;
   logic        s_pc_write, s_if_id_write, s_id_ex_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_bubble, s_mul_busy;
   logic [3:0]  s_stall_cycles;

   int total = 0;
   int bad   = 0;

   // Reference model state: cycles still owed to each activity.
   int flush_left = 0;
   int mul_left   = 0;
   int lu_left    = 0;
   int cnt16      = 0;
   int cnt4       = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(
      .REG_ADDR_W      (3),
      .MUL_LATENCY     (MUL_LAT),
      .LOAD_USE_STALLS (LU_ST),
      .FLUSH_CYCLES    (FL_CYC),
      .STALL_CNT_W     (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .id_ex_rt        (id_ex_rt),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_mul_start (id_ex_mul_start),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .id_ex_write     (id_ex_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_bubble   (ex_mem_bubble),
      .mul_busy        (mul_busy),
      .stall_cycles    (stall_cycles)
   );

   hazard_control_unit #(
      .REG_ADDR_W      (3),
      .MUL_LATENCY     (MUL_LAT),
      .LOAD_USE_STALLS (LU_ST),
      .FLUSH_CYCLES    (FL_CYC),
      .STALL_CNT_W     (4)
   ) dut_sat (
      .clk             (clk),
      .reset           (reset),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .id_ex_rt        (id_ex_rt),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_mul_start (id_ex_mul_start),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (s_pc_write),
      .if_id_write     (s_if_id_write),
      .id_ex_write     (s_id_ex_write),
      .if_id_flush     (s_if_id_flush),
      .id_ex_flush     (s_id_ex_flush),
      .ex_mem_bubble   (s_ex_mem_bubble),
      .mul_busy        (s_mul_busy),
      .stall_cycles    (s_stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic br, input logic mul, input logic mr,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] ert);
      logic e_pc, e_ifw, e_idw, e_iff, e_idf, e_bub, e_busy, hz;
      reset = rst; ex_branch_taken = br; id_ex_mul_start = mul; id_ex_mem_read = mr;
      if_id_rs = rs; if_id_rt = rt; id_ex_rt = ert;
      @(negedge clk);
      e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0; e_bub = 0; e_busy = 0;
      hz = mr && (ert == rs || ert == rt);
      if (rst) begin
         e_pc = 0; e_ifw = 0; e_idw = 0; e_iff = 1; e_idf = 1;
      end else if (flush_left > 0) begin
         e_iff = 1; e_idf = 1;
      end else if (mul_left > 0) begin
         e_busy = 1;
         if (mul_left > 1) begin e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1; end
      end else if (lu_left > 0) begin
         e_pc = 0; e_ifw = 0; e_idf = 1;
      end else if (br) begin
         e_iff = 1; e_idf = 1;
      end else if (mul) begin
         e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1; e_busy = 1;
      end else if (hz) begin
         e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      check("pc_write",      32'(pc_write),      32'(e_pc));
      check("if_id_write",   32'(if_id_write),   32'(e_ifw));
      check("id_ex_write",   32'(id_ex_write),   32'(e_idw));
      check("if_id_flush",   32'(if_id_flush),   32'(e_iff));
      check("id_ex_flush",   32'(id_ex_flush),   32'(e_idf));
      check("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e_bub));
      check("mul_busy",      32'(mul_busy),      32'(e_busy));
      check("stall_cycles",  32'(stall_cycles),  cnt16);
      check("sat_stall_cycles", 32'(s_stall_cycles), cnt4);
      check("sat_pc_write",  32'(s_pc_write),    32'(e_pc));
      @(posedge clk);
      if (rst) begin
         flush_left = 0; mul_left = 0; lu_left = 0; cnt16 = 0; cnt4 = 0;
      end else begin
         if (!e_pc) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (flush_left > 0) flush_left--;
         else if (mul_left > 0) mul_left--;
         else if (lu_left > 0) lu_left--;
         else if (br) flush_left = FL_CYC - 1;
         else if (mul) mul_left = MUL_LAT - 1;
         else if (hz) lu_left = LU_ST - 1;
      end
      #1;
   endtask

   initial begin
      reset = 1'b1; if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
      id_ex_mem_read = 1'b0; id_ex_mul_start = 1'b0; ex_branch_taken = 1'b0;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 3);
      // Reset held three cycles in the middle of a multiply.
      step(0, 0, 1, 0, 1, 2, 3);
      step(0, 0, 0, 0, 1, 2, 3);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 2, 3);
      step(0, 0, 0, 0, 1, 2, 3);
      // Load-use on rs, then no hazard with r2/r4 vs load r5.
      step(0, 0, 0, 1, 3, 6, 3);
      step(0, 0, 0, 0, 3, 6, 3);
      step(0, 0, 0, 1, 2, 4, 5);
      step(0, 0, 0, 1, 2, 4, 5);
      // Load-use on rt.
      step(0, 0, 0, 1, 0, 7, 7);
      // Multiply: 3 stall cycles, busy 4.
      step(0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
      // Branch together with a load-use hazard: branch wins.
      step(0, 1, 0, 1, 4, 0, 4);
      step(0, 0, 0, 1, 4, 0, 4);
      step(0, 0, 0, 0, 1, 2, 3);
      // Twenty multiplies push the 4-bit counter into saturation.
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 1, 0, 0, 0, 0);
         for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 1, 2, 3);
      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage core. It sits alongside forwarding_unit, handling every hazard that forwarding alone cannot resolve:
- load-use stalls
- multi-cycle multiply stalls in EX
- taken-branch flushes
It drives the PC and pipeline-register write enables and the flush/bubble controls, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_ADDR_W, 3, register-specifier width (8 architectural registers)
MUL_LATENCY, 4, total EX cycles for a multiply; legal range 2..15
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..3
FLUSH_CYCLES, 2, cycles IF/ID and ID/EX are flushed per taken branch; legal range 1..3
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  core clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
if_id_rs  in  REG_ADDR_W  source register A of the instruction in ID
if_id_rt  in  REG_ADDR_W  source register B of the instruction in ID
id_ex_rt  in  REG_ADDR_W  destination register of the load in EX
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_mul_start  in  1  instruction in EX is a multiply
ex_branch_taken  in  1  branch in EX resolved taken (1-cycle pulse)
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
id_ex_write  out  1  ID/EX register enable
if_id_flush  out  1  clear IF/ID to a NOP
id_ex_flush  out  1  load a bubble into ID/EX
ex_mem_bubble  out  1  load a bubble into EX/MEM
mul_busy  out  1  multiplier occupying EX
stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- State is registered; outputs are combinational from state, counter and inputs (Mealy), so hazards take effect in the detection cycle.
- States: RUN, LOAD_STALL, MUL_WAIT, FLUSH. Single down-counter cnt, 2 bits wide minimum, sized to cover MUL_LATENCY.
- Defaults (RUN, no event): pc_write=if_id_write=id_ex_write=1; all flush/bubble outputs 0; mul_busy=0.
- Reset cycle (reset=1): pc_write=if_id_write=id_ex_write=0, if_id_flush=id_ex_flush=1, ex_mem_bubble=0, mul_busy=0. Next state RUN, cnt=0, stall_cycles=0. Reset overrides every state, including mid-stall and mid-multiply.
- Load-use hazard: lu = id_ex_mem_read & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
- RUN priority: ex_branch_taken > id_ex_mul_start > lu.
- RUN + ex_branch_taken:
  - Assert if_id_flush=1 and id_ex_flush=1; enables stay 1 so the PC loads the target.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
- FLUSH: same outputs as the branch cycle. At cnt==0 return to RUN; otherwise decrement. ex_branch_taken and mul/lu are ignored.
- RUN + id_ex_mul_start: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, mul_busy=1; cnt=MUL_LATENCY-2; go to MUL_WAIT.
- MUL_WAIT: mul_busy=1.
  - cnt!=0: hold the stall outputs and decrement.
  - cnt==0 (release cycle): default enables, ex_mem_bubble=0; go to RUN.
  - Total stall cycles = MUL_LATENCY-1. All other inputs are ignored.
- RUN + lu: pc_write=if_id_write=0, id_ex_flush=1.
  - If LOAD_USE_STALLS>1, go to LOAD_STALL with cnt=LOAD_USE_STALLS-2.
  - LOAD_STALL repeats the same outputs; return to RUN after cnt==0.
  - lu is not re-evaluated inside LOAD_STALL.
- stall_cycles: increments on every non-reset cycle with pc_write=0 and saturates at all-ones.
- Forwarding: forwarding_unit is unchanged. The stalls above guarantee its EX/MEM and MEM/WB sources are valid when selected.

Decomposition:
- Shared pipeline package: state encoding localparams (RUN=0, LOAD_STALL=1, MUL_WAIT=2, FLUSH=3) and the REG_ADDR_W constant shared with forwarding_unit.
- One natural sub-module, hazard_compare: purely combinational lu detection. It is reusable by future ID-stage branch-compare hazard logic.

Test Plan:
- Reset held 3 cycles mid-MUL_WAIT -> reset-cycle outputs each cycle; then RUN defaults, stall_cycles=0.
- Load r3 in EX (id_ex_mem_read=1, id_ex_rt=3), ID reads if_id_rs=3 -> same cycle pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle, with the bubble in EX, defaults return; stall_cycles=1.
- Load r5 in EX, ID reads r2/r4 -> no stall; defaults held.
- id_ex_mul_start=1 with MUL_LATENCY=4 -> 3 cycles of pc_write=0 and ex_mem_bubble=1, mul_busy=1 for 4 cycles, resume on the 4th; stall_cycles=3.
- ex_branch_taken=1 together with lu=1 -> branch wins: if_id_flush=id_ex_flush=1 for 2 cycles, pc_write=1 throughout, no stall counted.
- Force stall_cycles near max (STALL_CNT_W=4 build), then 20 mul stalls -> counter saturates at 15 and does not wrap.
